// File: rtl/ctrl_cmd_issuer_if.sv
// ----------------------------------------------------------------------------
// ctrl_cmd_issuer_if
// Bundles the command stream and the controller-core command interface that
// ctrl_cmd_issuer sits between.
//   master : the issuer's view. It sinks the command stream, drives the core
//            strobes and data, and receives update_cycle_complete.
//   slave  : the host/harness view. It drives the command stream and the core
//            response, and observes everything else.
// Signals:
//   cmd_valid, cmd_ready, cmd_word[31:0], cmd_is_trigger : command stream
//   spi_data[31:0], spi_data_clock, latch_data,
//   control_trigger                                      : core inputs
//   update_cycle_complete                                : core response (async)
//   busy, timeout_err, done_pulse                        : status
// ----------------------------------------------------------------------------
interface ctrl_cmd_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_word;
  logic        cmd_is_trigger;
  logic [31:0] spi_data;
  logic        spi_data_clock;
  logic        latch_data;
  logic        control_trigger;
  logic        update_cycle_complete;
  logic        busy;
  logic        timeout_err;
  logic        done_pulse;

  modport master (
    input  cmd_valid,
    input  cmd_word,
    input  cmd_is_trigger,
    input  update_cycle_complete,
    output cmd_ready,
    output spi_data,
    output spi_data_clock,
    output latch_data,
    output control_trigger,
    output busy,
    output timeout_err,
    output done_pulse
  );

  modport slave (
    output cmd_valid,
    output cmd_word,
    output cmd_is_trigger,
    output update_cycle_complete,
    input  cmd_ready,
    input  spi_data,
    input  spi_data_clock,
    input  latch_data,
    input  control_trigger,
    input  busy,
    input  timeout_err,
    input  done_pulse
  );
endinterface

// File: rtl/ctrl_cmd_issuer.sv
// ----------------------------------------------------------------------------
// ctrl_cmd_issuer
// Host-side initiator for the controller core's command interface. Accepts
// one 32-bit command per valid/ready handshake and sequences it onto the core:
//   data command    : spi_data, one-cycle spi_data_clock, settle, latch_data
//                     held HOLD_CYCLES, then GAP_CYCLES of quiet.
//   trigger command : control_trigger held HOLD_CYCLES, then wait for a rising
//                     edge on update_cycle_complete (bounded by TIMEOUT_CYCLES),
//                     then GAP_CYCLES of quiet.
// Ports:
//   clock    : system clock
//   reset_n  : asynchronous active-low reset, released synchronously upstream
//   bus      : ctrl_cmd_issuer_if.master (command stream, core signals, status)
// Every output is driven straight from a flop.
// ----------------------------------------------------------------------------
module ctrl_cmd_issuer #(
  parameter int unsigned SETTLE_CYCLES  = 4,       // 1..255
  parameter int unsigned HOLD_CYCLES    = 4,       // 3..255, core ANDs 3 samples
  parameter int unsigned GAP_CYCLES     = 2,       // 1..255
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input logic               clock,
  input logic               reset_n,
  ctrl_cmd_issuer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLK_HI,
    SETTLE,
    LATCH,
    TRIG,
    WAIT_DONE,
    GAP
  } state_e;

  // Phase counters are loaded with N-1 so a phase lasts exactly N cycles.
  localparam logic [7:0]  SETTLE_LD  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LD    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]  GAP_LD     = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = TIMEOUT_CYCLES - 16'd1;

  state_e      state_q;
  logic [7:0]  phase_cnt_q;
  logic [15:0] to_cnt_q;

  logic        cmd_ready_q;
  logic [31:0] spi_data_q;
  logic        spi_clk_q;
  logic        latch_q;
  logic        trig_q;
  logic        busy_q;
  logic        timeout_err_q;
  logic        done_q;

  // update_cycle_complete synchronizer and edge-history flop
  logic        ucc_s1_q;
  logic        ucc_s2_q;
  logic        ucc_prev_q;
  logic        ucc_rise;

  // History keeps tracking in every state, so a level that is already high
  // when WAIT_DONE is entered never looks like a fresh edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ucc_s1_q   <= 1'b0;
      ucc_s2_q   <= 1'b0;
      ucc_prev_q <= 1'b0;
    end else begin
      ucc_s1_q   <= bus.update_cycle_complete;
      ucc_s2_q   <= ucc_s1_q;
      ucc_prev_q <= ucc_s2_q;
    end
  end

  assign ucc_rise = ucc_s2_q & ~ucc_prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      phase_cnt_q   <= 8'd0;
      to_cnt_q      <= 16'd0;
      cmd_ready_q   <= 1'b1;
      spi_data_q    <= 32'd0;
      spi_clk_q     <= 1'b0;
      latch_q       <= 1'b0;
      trig_q        <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // cmd_ready_q is high exactly in IDLE, so cmd_valid alone is the handshake.
        IDLE: begin
          if (bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.cmd_is_trigger) begin
              state_q       <= TRIG;
              trig_q        <= 1'b1;
              phase_cnt_q   <= HOLD_LD;
              timeout_err_q <= 1'b0;
            end else begin
              state_q    <= SETUP;
              spi_data_q <= bus.cmd_word;
            end
          end
        end

        // spi_data has been stable for one cycle before its capture clock.
        SETUP: begin
          state_q   <= CLK_HI;
          spi_clk_q <= 1'b1;
        end

        CLK_HI: begin
          state_q     <= SETTLE;
          spi_clk_q   <= 1'b0;
          phase_cnt_q <= SETTLE_LD;
        end

        // Lets the core's async data crossing settle before the latch.
        SETTLE: begin
          if (phase_cnt_q == 8'd0) begin
            state_q     <= LATCH;
            latch_q     <= 1'b1;
            phase_cnt_q <= HOLD_LD;
          end else begin
            phase_cnt_q <= phase_cnt_q - 8'd1;
          end
        end

        LATCH: begin
          if (phase_cnt_q == 8'd0) begin
            state_q     <= GAP;
            latch_q     <= 1'b0;
            phase_cnt_q <= GAP_LD;
          end else begin
            phase_cnt_q <= phase_cnt_q - 8'd1;
          end
        end

        TRIG: begin
          if (phase_cnt_q == 8'd0) begin
            state_q  <= WAIT_DONE;
            trig_q   <= 1'b0;
            to_cnt_q <= 16'd0;
          end else begin
            phase_cnt_q <= phase_cnt_q - 8'd1;
          end
        end

        // The edge is tested first so it wins a tie with the timeout.
        WAIT_DONE: begin
          if (ucc_rise) begin
            state_q     <= GAP;
            done_q      <= 1'b1;
            phase_cnt_q <= GAP_LD;
          end else if (to_cnt_q == TO_LAST) begin
            state_q       <= GAP;
            timeout_err_q <= 1'b1;
            phase_cnt_q   <= GAP_LD;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end

        GAP: begin
          if (phase_cnt_q == 8'd0) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            phase_cnt_q <= phase_cnt_q - 8'd1;
          end
        end

        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          spi_clk_q   <= 1'b0;
          latch_q     <= 1'b0;
          trig_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.spi_data        = spi_data_q;
  assign bus.spi_data_clock  = spi_clk_q;
  assign bus.latch_data      = latch_q;
  assign bus.control_trigger = trig_q;
  assign bus.busy            = busy_q;
  assign bus.timeout_err     = timeout_err_q;
  assign bus.done_pulse      = done_q;

endmodule

// File: doc/ctrl_cmd_issuer.md
Name: ctrl_cmd_issuer

Overview:
- Host-side initiator for the controller core's command interface.
- Takes 32-bit command words from a valid/ready stream and drives them onto the core inputs: the spi_data bus with its capture clock, a filtered latch_data strobe, and a filtered control_trigger strobe.
- For trigger commands, waits for the core's update_cycle_complete response, with a timeout.
- Sits in the test/host harness or the front-end bridge that feeds the controller core.

Parameters:
- SETTLE_CYCLES, 4, idle cycles after the spi_data_clock pulse, so the async data crossing settles before latch; range 1..255.
- HOLD_CYCLES, 4, cycles latch_data / control_trigger are held high; must be >=3 to pass the core's 3-sample AND filter; range 3..255.
- GAP_CYCLES, 2, cycles with all strobes low before the next command is accepted; range 1..255.
- TIMEOUT_CYCLES, 16'd4096, max cycles to wait for update_cycle_complete after a trigger.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command word available
- cmd_ready  output  1  issuer can accept a command
- cmd_word  input  32  command payload, ignored when cmd_is_trigger=1
- cmd_is_trigger  input  1  1 = issue control_trigger, 0 = issue data + latch
- spi_data  output  32  command word to the core's async crossing
- spi_data_clock  output  1  single-cycle capture clock for spi_data
- latch_data  output  1  latch strobe to the core
- control_trigger  output  1  trigger strobe to the core
- update_cycle_complete  input  1  response from the core; asynchronous to this block
- busy  output  1  high whenever the FSM is not in IDLE
- timeout_err  output  1  sticky; set when a trigger wait times out
- done_pulse  output  1  one-cycle pulse when a trigger completes normally

Behaviour:
- Reset (async assert, sync release): state IDLE, cmd_ready=1, spi_data=0, spi_data_clock=0, latch_data=0, control_trigger=0, busy=0, timeout_err=0, done_pulse=0, counters=0, sync flops=0.
- All outputs are registered. cmd_ready is high only in IDLE; a handshake is cmd_valid & cmd_ready at a rising edge.
- FSM states: IDLE, SETUP, CLK_HI, SETTLE, LATCH, TRIG, WAIT_DONE, GAP.
- Data command (cmd_is_trigger=0), accepted at edge E:
  - SETUP: spi_data<=cmd_word, 1 cycle.
  - CLK_HI: spi_data_clock=1, 1 cycle.
  - SETTLE: SETTLE_CYCLES cycles.
  - LATCH: latch_data=1, HOLD_CYCLES cycles.
  - GAP: GAP_CYCLES cycles, then IDLE.
  - With defaults: spi_data_clock high E+1..E+2, latch_data high E+6..E+10, cmd_ready high again after E+12.
  - spi_data holds its value until the next data command; trigger commands leave it unchanged.
- Trigger command (cmd_is_trigger=1), accepted at edge E:
  - timeout_err is cleared on accept.
  - TRIG: control_trigger=1, HOLD_CYCLES cycles.
  - WAIT_DONE: until a rising edge is seen on update_cycle_complete.
  - GAP, then IDLE.
- update_cycle_complete passes through a 2-flop synchronizer, then an edge detector on the synchronized value (previous=0, current=1).
  - Edge detection runs only in WAIT_DONE; its history register keeps updating in all states, so a level already high on entry is not an edge.
  - On the edge: done_pulse=1 for one cycle, go to GAP.
- Timeout: a 16-bit counter starts at 0 on entry to WAIT_DONE. When it reaches TIMEOUT_CYCLES-1 without an edge: timeout_err<=1, no done_pulse, go to GAP.
  - If the edge and the timeout land in the same cycle, the edge wins: done_pulse=1, timeout_err unchanged.
- Each phase counter is 8 bits, loaded with N-1 on phase entry and decremented; the phase exits when the counter is 0.
- latch_data and control_trigger are never high in the same cycle. spi_data_clock is never high while latch_data is high.
- cmd_valid asserted while busy has no effect; the command is held upstream.
- Reset mid-operation: all strobes drop immediately, the FSM returns to IDLE, and the in-flight command is discarded.

Test Plan:
1. Reset, then data command 0xA5A5_0001 with defaults -> cmd_ready low after E; spi_data=0xA5A5_0001 after E; spi_data_clock high exactly 1 cycle (E+1); latch_data high exactly 4 cycles (E+6..E+10); cmd_ready high after E+12.
2. Trigger command; drive update_cycle_complete high 20 cycles after accept -> control_trigger high exactly 4 cycles; done_pulse asserted 1 cycle, 3 cycles after the input rises (2-flop sync + edge); timeout_err=0; cmd_ready returns after GAP.
3. Trigger command with update_cycle_complete held low, TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 cycles in WAIT_DONE, no done_pulse; a following trigger command clears timeout_err on accept.
4. Back-to-back: cmd_valid held high with 3 queued commands (data, data, trigger) -> exactly 3 handshakes; no strobe overlap; at least GAP_CYCLES all-low cycles between commands.
5. Assert reset_n low during the LATCH phase -> latch_data falls asynchronously; after release, cmd_ready=1 and spi_data=0.
6. update_cycle_complete already high before the trigger is issued -> no done_pulse until it falls and rises again; timeout fires if it never re-rises.
